// File: rtl/cnt_full_pkg.sv
// Shared helpers for the async FIFO pointer counters.
// Both the write-side and read-side counters use these helpers.
package cnt_full_pkg;

    function automatic int fifo_depth(input int width);
        return 1 << (width - 1);
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin = gray;
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i + 1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/cnt_full_gray2bin.sv
// Combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at or above its position.
module cnt_full_gray2bin #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[WIDTH-1:i];
    end

endmodule

// File: rtl/cnt_full.sv
// Write-side pointer and flag generator for the async FIFO: binary/Gray
// write pointers, registered full/almost_full/level and a sticky overflow.
module cnt_full
    import cnt_full_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int AF_THRESH = fifo_depth(WIDTH) - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] cnt_gray_sync,
    output logic [WIDTH-1:0] cnt_bin,
    output logic [WIDTH-1:0] cnt_gray,
    output logic             full,
    output logic             almost_full,
    output logic [WIDTH-1:0] level,
    output logic             overflow
);

    // Full when the next write pointer differs from the read pointer only
    // in the top two Gray bits (same position, opposite wrap).
    localparam logic [WIDTH-1:0] FULL_MASK = WIDTH'(2'b11) << (WIDTH - 2);
    localparam logic [WIDTH-1:0] AF_T      = WIDTH'(AF_THRESH);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_full;
    logic             r_almost_full;
    logic [WIDTH-1:0] r_level;
    logic             r_overflow;

    logic             w_wr_ok;
    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray_next;
    logic [WIDTH-1:0] w_rd_bin;
    logic [WIDTH-1:0] w_level_d;
    logic             w_full_d;
    logic             w_af_d;

    cnt_full_gray2bin #(
        .WIDTH (WIDTH)
    ) u_rd_g2b (
        .i_gray (cnt_gray_sync),
        .o_bin  (w_rd_bin)
    );

    assign w_wr_ok     = en & ~r_full;
    assign w_bin_next  = r_bin + {{(WIDTH-1){1'b0}}, w_wr_ok};
    assign w_gray_next = WIDTH'(bin2gray(32'(w_bin_next)));
    assign w_level_d   = w_bin_next - w_rd_bin;
    assign w_full_d    = (w_gray_next == (cnt_gray_sync ^ FULL_MASK));
    assign w_af_d      = (w_level_d >= AF_T);

    // Pointer, flag and level registers; rst/clr dominate everything.
    always_ff @(posedge clk) begin
        if (rst | clr) begin
            r_bin         <= {WIDTH{1'b0}};
            r_gray        <= {WIDTH{1'b0}};
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_level       <= {WIDTH{1'b0}};
            r_overflow    <= 1'b0;
        end else begin
            r_bin         <= w_bin_next;
            r_gray        <= w_gray_next;
            r_full        <= w_full_d;
            r_almost_full <= w_af_d;
            r_level       <= w_level_d;
            if (en & r_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign cnt_bin     = r_bin;
    assign cnt_gray    = r_gray;
    assign full        = r_full;
    assign almost_full = r_almost_full;
    assign level       = r_level;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_cnt_full.sv
// Directed bench for cnt_full at WIDTH=4 (depth 8), AF_THRESH=6.
module tb_cnt_full;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       en;
    logic [3:0] cnt_gray_sync;
    logic [3:0] cnt_bin;
    logic [3:0] cnt_gray;
    logic       full;
    logic       almost_full;
    logic [3:0] level;
    logic       overflow;

    int n_cmp;
    int n_mis;

    // Gray code of 0..15, written out by hand.
    logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                  4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                  4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                  4'b1010, 4'b1011, 4'b1001, 4'b1000};
    // Expected cnt_gray after each of the 8 fill writes.
    logic [3:0] fill_gray [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                  4'b0111, 4'b0101, 4'b0100, 4'b1100};

    cnt_full #(
        .WIDTH     (4),
        .AF_THRESH (6)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clr           (clr),
        .en            (en),
        .cnt_gray_sync (cnt_gray_sync),
        .cnt_bin       (cnt_bin),
        .cnt_gray      (cnt_gray),
        .full          (full),
        .almost_full   (almost_full),
        .level         (level),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_bin, input logic [3:0] e_gray,
                             input logic e_full, input logic e_af, input logic [3:0] e_lvl,
                             input logic e_ovf);
        check({tag, ".cnt_bin"}, 32'(cnt_bin), 32'(e_bin));
        check({tag, ".cnt_gray"}, 32'(cnt_gray), 32'(e_gray));
        check({tag, ".full"}, 32'(full), 32'(e_full));
        check({tag, ".almost_full"}, 32'(almost_full), 32'(e_af));
        check({tag, ".level"}, 32'(level), 32'(e_lvl));
        check({tag, ".overflow"}, 32'(overflow), 32'(e_ovf));
    endtask

    initial begin
        logic [3:0] b;
        n_cmp = 0;
        n_mis = 0;
        rst = 1'b1;
        clr = 1'b0;
        en  = 1'b1;
        cnt_gray_sync = 4'b0000;

        // Reset wins over en.
        step();
        step();
        check_all("reset", 4'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
        rst = 1'b0;

        // Partial fill then clear at cnt_bin=5.
        for (int i = 0; i < 5; i++) step();
        check_all("prefill5", 4'd5, 4'b0111, 1'b0, 1'b0, 4'd5, 1'b0);
        clr = 1'b1;
        step();
        check_all("clr_midfill", 4'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
        clr = 1'b0;

        // Fill to 8 with read pointer at 0.
        for (int k = 1; k <= 8; k++) begin
            step();
            check_all($sformatf("fill%0d", k), 4'(k), fill_gray[k-1],
                      (k == 8), (k >= 6), 4'(k), 1'b0);
        end

        // Writes while full are dropped and latch overflow.
        step();
        check_all("ovf1", 4'd8, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1);
        step();
        check_all("ovf2", 4'd8, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1);
        en = 1'b0;
        step();
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Read side advances to 3: full releases one clk later.
        cnt_gray_sync = 4'b0010;
        step();
        check_all("drain", 4'd8, 4'b1100, 1'b0, 1'b0, 4'd5, 1'b1);
        clr = 1'b1;
        step();
        check_all("clr_ovf", 4'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
        clr = 1'b0;
        cnt_gray_sync = 4'b0000;

        // Wrap with the read pointer trailing by 2.
        en = 1'b1;
        step();
        step();
        check("wrap_setup.level", 32'(level), 32'd2);
        b = 4'd2;
        for (int i = 0; i < 15; i++) begin
            cnt_gray_sync = gray_tab[b - 4'd1];
            step();
            b = b + 4'd1;
            check($sformatf("wrap%0d.cnt_bin", i), 32'(cnt_bin), 32'(b));
            check($sformatf("wrap%0d.cnt_gray", i), 32'(cnt_gray), 32'(gray_tab[b]));
            check($sformatf("wrap%0d.level", i), 32'(level), 32'd2);
            check($sformatf("wrap%0d.full", i), 32'(full), 32'd0);
            if (b == 4'd15) check("wrap_top_gray", 32'(cnt_gray), 32'(4'b1000));
            else if (b == 4'd0) check("wrap_zero_gray", 32'(cnt_gray), 32'(4'b0000));
            else check("wrap_af", 32'(almost_full), 32'd0);
        end

        // Read pointer held at 15: climb to level 7 at cnt_bin=6.
        for (int i = 0; i < 5; i++) step();
        check_all("pre_simul", 4'd6, 4'b0101, 1'b0, 1'b1, 4'd7, 1'b0);

        // Write and read advance together: level holds.
        cnt_gray_sync = 4'b0000;
        step();
        check_all("simul", 4'd7, 4'b0100, 1'b0, 1'b1, 4'd7, 1'b0);

        // One more write fills after the wrap.
        step();
        check_all("full_after_wrap", 4'd8, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0);
        en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
